// File: rtl/eeprom_i2c_master.sv
// Memory-mapped single-byte I2C master for EEPROM access: CTRL/DATA/STATUS
// registers drive a START / byte / STOP sequencer with open-drain line outputs.
module eeprom_i2c_master #(
  parameter logic [23:0] BASE    = 24'h2070,
  parameter int unsigned CLK_DIV = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_ce,
  input  logic        bus_write,
  input  logic        bus_read,
  input  logic [23:0] bus_address_in,
  input  logic [7:0]  bus_data_in,
  output logic [7:0]  bus_data_out,
  output logic        scl_out,
  output logic        sda_out,
  input  logic        sda_in,
  output logic        irq_done
);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_WBIT, S_WACK, S_RBIT, S_RACK, S_STOP
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  phase_q, phase_d;
  logic [7:0]  tick_q, tick_d;
  logic [2:0]  bit_q, bit_d;
  logic [4:0]  ctrl_q, ctrl_d;
  logic [7:0]  tx_q, tx_d;
  logic [7:0]  rx_q, rx_d;
  logic        busy_q, busy_d;
  logic        nack_q, nack_d;
  logic        done_q, done_d;
  logic        irq_q, irq_d;
  logic        scl_q, scl_d;
  logic        sda_q, sda_d;

  logic        sel_ctrl, sel_data, sel_stat;
  logic        accept, last_tick, fin;

  assign sel_ctrl  = (bus_address_in == BASE);
  assign sel_data  = (bus_address_in == BASE + 24'd1);
  assign sel_stat  = (bus_address_in == BASE + 24'd2);
  assign accept    = bus_write && sel_ctrl && !busy_q && (bus_data_in[3:0] != 4'h0);
  assign last_tick = (tick_q == 8'(CLK_DIV - 1));

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    ctrl_d  = ctrl_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    busy_d  = busy_q;
    nack_d  = nack_q;
    done_d  = done_q;
    irq_d   = 1'b0;
    fin     = 1'b0;

    if (accept) begin
      ctrl_d  = bus_data_in[4:0];
      nack_d  = 1'b0;
      done_d  = 1'b0;
      busy_d  = 1'b1;
      phase_d = '0;
      tick_d  = '0;
      bit_d   = '0;
      if (bus_data_in[0])      state_d = S_START;
      else if (bus_data_in[1]) state_d = S_WBIT;
      else if (bus_data_in[2]) state_d = S_RBIT;
      else                     state_d = S_STOP;
    end else if (bus_write && sel_data && !busy_q) begin
      tx_d = bus_data_in;
    end

    if (state_q != S_IDLE) begin
      tick_d = last_tick ? '0 : tick_q + 8'd1;
      if (last_tick) begin
        phase_d = phase_q + 2'd1;
        // Sample on the final tick of q1, while SCL is still high.
        if (phase_q == 2'd1) begin
          if (state_q == S_WACK) nack_d = sda_in;
          if (state_q == S_RBIT) rx_d = {rx_q[6:0], sda_in};
        end
        if (phase_q == 2'd3) begin
          case (state_q)
            S_START: begin
              if (ctrl_q[1])      state_d = S_WBIT;
              else if (ctrl_q[2]) state_d = S_RBIT;
              else if (ctrl_q[3]) state_d = S_STOP;
              else                fin = 1'b1;
            end
            S_WBIT: begin
              bit_d = bit_q + 3'd1;
              if (bit_q == 3'd7) state_d = S_WACK;
            end
            S_RBIT: begin
              bit_d = bit_q + 3'd1;
              if (bit_q == 3'd7) state_d = S_RACK;
            end
            S_WACK, S_RACK: begin
              if (ctrl_q[3]) state_d = S_STOP;
              else           fin = 1'b1;
            end
            default: fin = 1'b1;
          endcase
        end
      end
    end

    if (fin) begin
      state_d = S_IDLE;
      busy_d  = 1'b0;
      done_d  = 1'b1;
      irq_d   = 1'b1;
    end
  end

  // Line levels are derived from the next state so they register alongside it.
  always_comb begin
    scl_d = scl_q;
    sda_d = sda_q;
    case (state_d)
      S_START: begin
        scl_d = (phase_d != 2'd3);
        sda_d = !phase_d[1];
      end
      S_WBIT: begin
        scl_d = ^phase_d;
        sda_d = tx_q[3'd7 - bit_d];
      end
      S_WACK, S_RBIT: begin
        scl_d = ^phase_d;
        sda_d = 1'b1;
      end
      S_RACK: begin
        scl_d = ^phase_d;
        sda_d = ctrl_d[4];
      end
      S_STOP: begin
        scl_d = (phase_d != 2'd0);
        sda_d = phase_d[1];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      phase_q <= '0;
      tick_q  <= '0;
      bit_q   <= '0;
      ctrl_q  <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      busy_q  <= 1'b0;
      nack_q  <= 1'b0;
      done_q  <= 1'b0;
      irq_q   <= 1'b0;
      scl_q   <= 1'b1;
      sda_q   <= 1'b1;
    end else if (clk_ce) begin
      state_q <= state_d;
      phase_q <= phase_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      ctrl_q  <= ctrl_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      busy_q  <= busy_d;
      nack_q  <= nack_d;
      done_q  <= done_d;
      irq_q   <= irq_d;
      scl_q   <= scl_d;
      sda_q   <= sda_d;
    end
  end

  always_comb begin
    bus_data_out = '0;
    if (bus_read) begin
      if (sel_ctrl)      bus_data_out = {3'b000, ctrl_q};
      else if (sel_data) bus_data_out = rx_q;
      else if (sel_stat) bus_data_out = {5'b00000, done_q, nack_q, busy_q};
    end
  end

  assign scl_out  = scl_q;
  assign sda_out  = sda_q;
  assign irq_done = irq_q;

endmodule
